// File: rtl/ahb_timer_pkg.sv
// ahb_timer_pkg: shared definitions for the AHB-Lite timer scheduler.
//   state_t        sequencer states
//   HTRANS_*       AHB-Lite transfer type encodings used by the master port
//   ADDR_*         timer slave register addresses
package ahb_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DIS,
    ST_WR_CLR,
    ST_WR_EN,
    ST_WAIT_IRQ,
    ST_WR_STOP,
    ST_FIN
  } state_t;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  localparam logic [29:0] ADDR_CTRL     = 30'h0;
  localparam logic [29:0] ADDR_RESTART  = 30'h4;

endpackage

// File: rtl/ahb_timer_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   : request vector
//   ptr   : index that has highest priority this round
//   gnt   : one-hot winner (zero when no request)
//   idx   : binary index of the winner
//   valid : at least one request present
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    // Scan from ptr upwards, wrapping; first set bit wins.
    for (int unsigned off = 0; off < NREQ; off++) begin
      j = (32'(ptr) + off) % NREQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_timer_sched.sv
// ahb_timer_sched: shares one AHB-Lite timer slave between NREQ requesters.
// Each granted requester gets a one-shot timeout: the timer is disabled,
// cleared and loaded with the target, enabled, then stopped after its
// interrupt (or when the owner drops its request), and the owner is told.
//
// Ports:
//   HCLK, HRESET      clock, synchronous active-high reset
//   req/timeout       per-requester level request and packed TW-bit timeout
//   grant/done        one-hot owner, one-cycle done pulse to the owner
//   aborted/err/busy  abort pulse, bus/watchdog error pulse, not-idle flag
//   M_*               single-master AHB-Lite write port to the timer slave
//
// Build option: define AHB_TIMER_SCHED_WDOG_EN to add a watchdog that
// abandons the wait WDOG_MARGIN cycles beyond the programmed target.
module ahb_timer_sched
  import ahb_timer_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TW          = 30,
  parameter int unsigned WDOG_MARGIN = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*TW-1:0] timeout,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               aborted,
  output logic               err,
  output logic               busy,
  output logic               M_HSEL,
  output logic               M_WORK,
  output logic [29:0]        M_HADDR,
  output logic               M_HWRITE,
  output logic [1:0]         M_HTRANS,
  output logic [31:0]        M_HWDATA,
  input  logic               M_HREADY,
  input  logic               M_HRESP,
  input  logic               M_IRQ
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time range check on the configuration.
  if (NREQ < 2 || NREQ > 8 || TW > 32 || WDOG_MARGIN > 255) begin : g_bad_cfg
    $error("ahb_timer_sched: unsupported parameter combination");
  end

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [TW-1:0]   tgt;
  logic            abort_f;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_valid;
  logic [TW-1:0]   sel_to;
  logic [31:0]     tgt_word;
  logic            in_xfer;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign sel_to   = timeout[arb_idx*TW +: TW];
  assign tgt_word = 32'(tgt);
  assign in_xfer  = (state == ST_WR_DIS) || (state == ST_WR_CLR) ||
                    (state == ST_WR_EN)  || (state == ST_WR_STOP);

  assign busy     = (state != ST_IDLE);
  assign M_WORK   = M_HSEL;
  assign M_HWRITE = M_HSEL;

`ifdef AHB_TIMER_SCHED_WDOG_EN
  logic [TW+7:0] wcnt;
  logic [TW+7:0] wlimit;
  assign wlimit = (TW+8)'(tgt) + (TW+8)'(WDOG_MARGIN);
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      tgt      <= '0;
      abort_f  <= 1'b0;
      grant    <= '0;
      done     <= '0;
      aborted  <= 1'b0;
      err      <= 1'b0;
      M_HSEL   <= 1'b0;
      M_HADDR  <= '0;
      M_HTRANS <= HTRANS_IDLE;
      M_HWDATA <= '0;
`ifdef AHB_TIMER_SCHED_WDOG_EN
      wcnt     <= '0;
`endif
    end else begin
      done    <= '0;
      aborted <= 1'b0;
      // Bus errors are flagged once, on the completing beat; the watchdog
      // branch below may override this in WAIT_IRQ.
      err     <= in_xfer && M_HREADY && M_HRESP;

      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            owner    <= arb_idx;
            grant    <= arb_gnt;
            tgt      <= sel_to | TW'(1);
            abort_f  <= 1'b0;
            M_HSEL   <= 1'b1;
            M_HTRANS <= HTRANS_NONSEQ;
            M_HADDR  <= ADDR_CTRL;
            M_HWDATA <= '0;
            state    <= ST_WR_DIS;
          end
        end
        ST_WR_DIS: begin
          if (M_HREADY) begin
            M_HADDR  <= ADDR_RESTART;
            M_HWDATA <= tgt_word;
            state    <= ST_WR_CLR;
          end
        end
        ST_WR_CLR: begin
          if (M_HREADY) begin
            M_HADDR  <= ADDR_CTRL;
            M_HWDATA <= tgt_word;
            state    <= ST_WR_EN;
          end
        end
        ST_WR_EN: begin
          if (M_HREADY) begin
            M_HSEL   <= 1'b0;
            M_HTRANS <= HTRANS_IDLE;
            M_HADDR  <= '0;
            M_HWDATA <= '0;
            state    <= ST_WAIT_IRQ;
`ifdef AHB_TIMER_SCHED_WDOG_EN
            wcnt     <= '0;
`endif
          end
        end
        ST_WAIT_IRQ: begin
          // IRQ has priority over a simultaneous request drop.
          if (M_IRQ || !req[owner]
`ifdef AHB_TIMER_SCHED_WDOG_EN
              || (wcnt == wlimit)
`endif
             ) begin
            abort_f  <= !M_IRQ;
`ifdef AHB_TIMER_SCHED_WDOG_EN
            if (!M_IRQ && req[owner]) err <= 1'b1;
`endif
            M_HSEL   <= 1'b1;
            M_HTRANS <= HTRANS_NONSEQ;
            M_HADDR  <= ADDR_CTRL;
            M_HWDATA <= '0;
            state    <= ST_WR_STOP;
          end
`ifdef AHB_TIMER_SCHED_WDOG_EN
          else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        ST_WR_STOP: begin
          if (M_HREADY) begin
            M_HSEL   <= 1'b0;
            M_HTRANS <= HTRANS_IDLE;
            M_HADDR  <= '0;
            state    <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (abort_f) aborted <= 1'b1;
          else         done    <= grant;
          grant <= '0;
          ptr   <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_timer_sched.sv
module tb_ahb_timer_sched;

  localparam int NREQ = 4;
  localparam int TW   = 30;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic [NREQ-1:0]    req;
  logic [NREQ*TW-1:0] timeout;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               aborted;
  logic               err;
  logic               busy;
  logic               M_HSEL;
  logic               M_WORK;
  logic [29:0]        M_HADDR;
  logic               M_HWRITE;
  logic [1:0]         M_HTRANS;
  logic [31:0]        M_HWDATA;
  logic               M_HREADY;
  logic               M_HRESP;
  logic               M_IRQ;

  int n_assert = 0;
  int n_fail   = 0;

  ahb_timer_sched #(.NREQ(NREQ), .TW(TW), .WDOG_MARGIN(16)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .req      (req),
    .timeout  (timeout),
    .grant    (grant),
    .done     (done),
    .aborted  (aborted),
    .err      (err),
    .busy     (busy),
    .M_HSEL   (M_HSEL),
    .M_WORK   (M_WORK),
    .M_HADDR  (M_HADDR),
    .M_HWRITE (M_HWRITE),
    .M_HTRANS (M_HTRANS),
    .M_HWDATA (M_HWDATA),
    .M_HREADY (M_HREADY),
    .M_HRESP  (M_HRESP),
    .M_IRQ    (M_IRQ)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL time_limit: observed simulation still running, expected completion");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic sel, input logic [29:0] a,
                         input logic [31:0] d);
    chk({tag, ".hsel"},   32'(M_HSEL),   32'(sel));
    chk({tag, ".work"},   32'(M_WORK),   32'(sel));
    chk({tag, ".hwrite"}, 32'(M_HWRITE), 32'(sel));
    chk({tag, ".htrans"}, 32'(M_HTRANS), sel ? 32'h2 : 32'h0);
    chk({tag, ".haddr"},  32'(M_HADDR),  32'(a));
    chk({tag, ".hwdata"}, M_HWDATA,      d);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  // Full sequence from IDLE with the request already presented, IRQ given
  // one cycle into WAIT_IRQ.
  task automatic do_seq(input string tag, input logic [3:0] g, input logic [31:0] t);
    tick();
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk_bus({tag, ".dis"}, 1'b1, 30'h0, 32'h0);
    tick();
    chk_bus({tag, ".clr"}, 1'b1, 30'h4, t);
    tick();
    chk_bus({tag, ".en"}, 1'b1, 30'h0, t);
    tick();
    chk_bus({tag, ".wait"}, 1'b0, 30'h0, 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h1);
    M_IRQ = 1'b1;
    tick();
    M_IRQ = 1'b0;
    chk_bus({tag, ".stop"}, 1'b1, 30'h0, 32'h0);
    tick();
    chk({tag, ".fin_done"}, 32'(done), 32'h0);
    chk({tag, ".fin_grant"}, 32'(grant), 32'(g));
    tick();
    chk({tag, ".done"}, 32'(done), 32'(g));
    chk({tag, ".grant_clr"}, 32'(grant), 32'h0);
    chk({tag, ".aborted"}, 32'(aborted), 32'h0);
  endtask

  initial begin
    HRESET   = 1'b1;
    req      = '0;
    timeout  = '0;
    M_HREADY = 1'b1;
    M_HRESP  = 1'b0;
    M_IRQ    = 1'b0;
    timeout[0*TW +: TW] = 30'd4;
    timeout[1*TW +: TW] = 30'd7;
    timeout[2*TW +: TW] = 30'd10;
    timeout[3*TW +: TW] = 30'd0;
    do_reset();

    // Reset state
    chk("rst.grant", 32'(grant), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    chk("rst.aborted", 32'(aborted), 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk_bus("rst", 1'b0, 30'h0, 32'h0);

    // Single request, timeout 10 -> target 11
    req = 4'b0100;
    do_seq("single", 4'b0100, 32'd11);
    req = '0;
    tick();
    chk("single.done_clr", 32'(done), 32'h0);
    chk("single.idle", 32'(busy), 32'h0);

    // Contention from pointer 0: order 0,1,3,0
    do_reset();
    req = 4'b1011;
    do_seq("rr0", 4'b0001, 32'd5);
    do_seq("rr1", 4'b0010, 32'd7);
    do_seq("rr3", 4'b1000, 32'd1);
    do_seq("rr0b", 4'b0001, 32'd5);
    req = '0;
    tick();
    chk("rr.idle", 32'(busy), 32'h0);

    // Abort: requester 1 drops in WAIT_IRQ (pointer is now 1)
    req = 4'b0010;
    tick();
    chk("abt.grant", 32'(grant), 32'h2);
    tick();
    tick();
    tick();
    tick();
    chk_bus("abt.wait", 1'b0, 30'h0, 32'h0);
    req = '0;
    tick();
    chk_bus("abt.stop", 1'b1, 30'h0, 32'h0);
    tick();
    chk("abt.fin", 32'(aborted), 32'h0);
    tick();
    chk("abt.aborted", 32'(aborted), 32'h1);
    chk("abt.no_done", 32'(done), 32'h0);
    chk("abt.grant_clr", 32'(grant), 32'h0);
    tick();
    chk("abt.aborted_clr", 32'(aborted), 32'h0);

    // IRQ and request drop together: IRQ wins
    req = 4'b0010;
    tick();
    chk("both.grant", 32'(grant), 32'h2);
    tick();
    tick();
    tick();
    req   = '0;
    M_IRQ = 1'b1;
    tick();
    M_IRQ = 1'b0;
    chk_bus("both.stop", 1'b1, 30'h0, 32'h0);
    tick();
    tick();
    chk("both.done", 32'(done), 32'h2);
    chk("both.aborted", 32'(aborted), 32'h0);

    // Wait states during WR_CLR (pointer is 2)
    req = 4'b0100;
    tick();
    chk("ws.grant", 32'(grant), 32'h4);
    tick();
    chk_bus("ws.clr", 1'b1, 30'h4, 32'd11);
    M_HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_bus("ws.hold", 1'b1, 30'h4, 32'd11);
    end
    M_HREADY = 1'b1;
    tick();
    chk_bus("ws.en", 1'b1, 30'h0, 32'd11);
    tick();
    chk_bus("ws.wait", 1'b0, 30'h0, 32'h0);
    M_IRQ = 1'b1;
    tick();
    M_IRQ = 1'b0;
    req   = '0;
    tick();
    tick();
    chk("ws.done", 32'(done), 32'h4);

    // HRESP error on WR_EN (pointer is 3, timeout 0 -> target 1)
    req = 4'b1000;
    tick();
    chk("er.grant", 32'(grant), 32'h8);
    tick();
    tick();
    chk_bus("er.en", 1'b1, 30'h0, 32'd1);
    chk("er.err_before", 32'(err), 32'h0);
    M_HRESP = 1'b1;
    tick();
    M_HRESP = 1'b0;
    chk("er.err", 32'(err), 32'h1);
    tick();
    chk("er.err_clr", 32'(err), 32'h0);
    M_IRQ = 1'b1;
    tick();
    M_IRQ = 1'b0;
    req   = '0;
    tick();
    tick();
    chk("er.done", 32'(done), 32'h8);

    // Reset while in WAIT_IRQ
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    chk("mr.busy", 32'(busy), 32'h1);
    HRESET = 1'b1;
    tick();
    chk("mr.grant", 32'(grant), 32'h0);
    chk("mr.busy0", 32'(busy), 32'h0);
    chk("mr.done", 32'(done), 32'h0);
    chk("mr.aborted", 32'(aborted), 32'h0);
    chk_bus("mr", 1'b0, 30'h0, 32'h0);
    HRESET = 1'b0;
    req    = '0;
    tick();

`ifdef AHB_TIMER_SCHED_WDOG_EN
    // Watchdog: timeout 5 -> target 5, expires after 5+16 idle cycles
    do_reset();
    timeout[0*TW +: TW] = 30'd5;
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    chk_bus("wd.wait", 1'b0, 30'h0, 32'h0);
    for (int k = 0; k < 21; k++) tick();
    chk("wd.no_err_yet", 32'(err), 32'h0);
    tick();
    chk("wd.err", 32'(err), 32'h1);
    chk_bus("wd.stop", 1'b1, 30'h0, 32'h0);
    tick();
    tick();
    chk("wd.aborted", 32'(aborted), 32'h1);
    chk("wd.no_done", 32'(done), 32'h0);
    req = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
